// File: rtl/temp_avg_ctrl.sv
// temp_avg_ctrl: windowed temperature accumulator plus an iterative
// restoring divider that produces the window average, one quotient bit
// per clock, behind a busy/done handshake.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   sample_valid      a sample is present this cycle
//   sample            unsigned temperature sample
//   avg_req           close the open window and average it (IDLE only)
//   busy              high while quotient bits are being produced
//   done              one-cycle pulse when avg/rem/dz update
//   avg, rem          quotient and remainder of sum/count, held
//   dz                last closed window had zero samples, held
//   sat               sticky: a sample was dropped at full count
//   sample_cnt        samples in the open window
//
// Optional build macro AVG_ROUND_EN: avg rounds half up instead of
// truncating; rem still reports the raw remainder.

module temp_avg_ctrl #(
  parameter int SAMPLE_W = 8,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                avg_req,
  output logic                busy,
  output logic                done,
  output logic [15:0]         avg,
  output logic [15:0]         rem,
  output logic                dz,
  output logic                sat,
  output logic [CNT_W-1:0]    sample_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIN
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  state_t state_n;

  logic [15:0]      sum;
  logic [CNT_W-1:0] cnt;

  logic [15:0] num;
  logic [15:0] den;
  logic [15:0] quo;
  logic [15:0] rmd;
  logic [3:0]  idx;
  logic        zflag;

  logic        cnt_full;
  logic        take;
  logic        accept;
  logic [15:0] sum_cl;
  logic [15:0] cnt_cl;

  logic [16:0] r_sh;
  logic        r_ge;
  logic [15:0] r_next;
  logic [15:0] avg_fin;

  assign cnt_full = (cnt == CNT_MAX);
  assign take     = sample_valid && !cnt_full;
  assign accept   = (state == IDLE) && avg_req;

  // A sample arriving with the request belongs to the closing window.
  assign sum_cl = sum + (take ? 16'(sample) : 16'd0);
  assign cnt_cl = 16'(cnt) + (take ? 16'd1 : 16'd0);

  // Shift in the next dividend bit; 17 bits keeps the compare exact.
  assign r_sh   = {rmd, num[idx]};
  assign r_ge   = (r_sh >= {1'b0, den});
  assign r_next = r_ge ? 16'(r_sh - {1'b0, den}) : r_sh[15:0];

  always_comb begin
    avg_fin = quo;
`ifdef AVG_ROUND_EN
    if ({rmd, 1'b0} >= {1'b0, den}) begin
      avg_fin = quo + 16'd1;
    end
`else
    avg_fin = quo;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (avg_req) begin
          state_n = (cnt_cl == 16'd0) ? FIN : DIV;
        end
      end
      DIV: begin
        if (idx == 4'd0) begin
          state_n = FIN;
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Window accumulator runs in every state; closing a window wins
  // over a saturating drop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (accept) begin
      sum <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (sample_valid) begin
      if (cnt_full) begin
        sat <= 1'b1;
      end else begin
        sum <= sum + 16'(sample);
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num   <= '0;
      den   <= '0;
      quo   <= '0;
      rmd   <= '0;
      idx   <= '0;
      zflag <= 1'b0;
    end else begin
      if (accept) begin
        num   <= sum_cl;
        den   <= cnt_cl;
        quo   <= '0;
        rmd   <= '0;
        idx   <= 4'hf;
        zflag <= (cnt_cl == 16'd0);
      end else if (state == DIV) begin
        rmd      <= r_next;
        quo[idx] <= r_ge;
        idx      <= idx - 4'd1;
      end
    end
  end

  // Registered handshake: busy covers the cycles after each
  // quotient-bit edge, done follows the FIN edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      avg  <= '0;
      rem  <= '0;
      dz   <= 1'b0;
    end else begin
      busy <= (state == DIV);
      done <= (state == FIN);
      if (state == FIN) begin
        if (zflag) begin
          avg <= '0;
          rem <= '0;
          dz  <= 1'b1;
        end else begin
          avg <= avg_fin;
          rem <= rmd;
          dz  <= 1'b0;
        end
      end
    end
  end

  assign sample_cnt = cnt;

endmodule

// File: tb/tb_temp_avg_ctrl.sv
// tb_temp_avg_ctrl: directed scenarios plus randomized traffic checked
// against a window/queue-level reference model of the averager.

module tb_temp_avg_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [7:0]  sample;
  logic        avg_req;
  logic        busy;
  logic        done;
  logic [15:0] avg;
  logic [15:0] rem;
  logic        dz;
  logic        sat;
  logic [7:0]  sample_cnt;

  int vectors = 0;
  int miscompares = 0;

  temp_avg_ctrl #(.SAMPLE_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid),
    .sample(sample), .avg_req(avg_req), .busy(busy), .done(done),
    .avg(avg), .rem(rem), .dz(dz), .sat(sat), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state: edge counter, open window, pending result.
  int e = 0;
  int m_sum = 0;
  int m_cnt = 0;
  bit m_sat = 0;
  bit m_busy = 0;
  bit m_done = 0;
  bit pend = 0;
  int acc_edge = -100;
  int done_edge = -100;
  int next_ok = 0;
  int p_avg, p_rem;
  bit p_dz;
  int x_avg = 0;
  int x_rem = 0;
  bit x_dz = 0;

  function automatic void model_edge(bit rs, bit v, int s, bit r);
    int cs, cc;
    if (rs) begin
      m_sum = 0; m_cnt = 0; m_sat = 0; pend = 0;
      m_busy = 0; m_done = 0;
      x_avg = 0; x_rem = 0; x_dz = 0;
      next_ok = e + 1;
      return;
    end
    m_busy = pend && !p_dz && e >= acc_edge + 1 && e <= acc_edge + 16;
    m_done = pend && e == done_edge;
    if (m_done) begin
      x_avg = p_avg; x_rem = p_rem; x_dz = p_dz; pend = 0;
    end
    if (r && !pend && e >= next_ok) begin
      cs = m_sum; cc = m_cnt;
      if (v && m_cnt < 255) begin cs += s; cc++; end
      if (cc == 0) begin
        p_avg = 0; p_rem = 0; p_dz = 1; done_edge = e + 1;
      end else begin
        p_avg = cs / cc; p_rem = cs % cc; p_dz = 0;
`ifdef AVG_ROUND_EN
        if (2 * p_rem >= cc) p_avg++;
`endif
        done_edge = e + 17;
      end
      acc_edge = e; next_ok = done_edge + 1; pend = 1;
      m_sum = 0; m_cnt = 0; m_sat = 0;
    end else if (v) begin
      if (m_cnt < 255) begin m_sum += s; m_cnt++; end
      else m_sat = 1;
    end
  endfunction

  task automatic step(input bit rs, input bit v, input int s, input bit r);
    reset = rs; sample_valid = v; sample = s[7:0]; avg_req = r;
    @(posedge clk);
    e++;
    model_edge(rs, v, s, r);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %0b expected 0", done); end
    vectors++; if (avg !== 16'd0) begin miscompares++; $display("FAIL rst_avg: got %0d expected 0", avg); end
    vectors++; if (rem !== 16'd0) begin miscompares++; $display("FAIL rst_rem: got %0d expected 0", rem); end
    vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL rst_dz: got %0b expected 0", dz); end
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL rst_sat: got %0b expected 0", sat); end
    vectors++; if (sample_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_cnt: got %0d expected 0", sample_cnt); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_basic();
    int c, dn, bz, de, ea;
`ifdef AVG_ROUND_EN
    ea = 22;
`else
    ea = 21;
`endif
    for (int k = 20; k < 24; k++) step(0, 1, k, 0);
    vectors++; if (sample_cnt !== 8'd4) begin miscompares++; $display("FAIL basic_cnt: got %0d expected 4", sample_cnt); end
    step(0, 0, 0, 1);
    c = e; dn = 0; bz = 0; de = -1;
    repeat (20) begin
      step(0, 0, 0, 0);
      if (busy === 1'b1) bz++;
      if (done === 1'b1) begin dn++; de = e - c; end
      vectors++; if (busy !== m_busy) begin miscompares++; $display("FAIL basic_busy: got %0b expected %0b at edge %0d", busy, m_busy, e - c); end
    end
    vectors++; if (dn != 1) begin miscompares++; $display("FAIL basic_ndone: got %0d expected 1", dn); end
    vectors++; if (de != 17) begin miscompares++; $display("FAIL basic_lat: got %0d expected 17", de); end
    vectors++; if (bz != 16) begin miscompares++; $display("FAIL basic_busycyc: got %0d expected 16", bz); end
    vectors++; if (avg !== 16'(ea)) begin miscompares++; $display("FAIL basic_avg: got %0d expected %0d", avg, ea); end
    vectors++; if (rem !== 16'd2) begin miscompares++; $display("FAIL basic_rem: got %0d expected 2", rem); end
    vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL basic_dz: got %0b expected 0", dz); end
  endtask

  task automatic test_zero();
    int c, de, bz;
    step(0, 0, 0, 1);
    c = e; de = -1; bz = 0;
    repeat (4) begin
      step(0, 0, 0, 0);
      if (busy === 1'b1) bz++;
      if (done === 1'b1) de = e - c;
    end
    vectors++; if (de != 1) begin miscompares++; $display("FAIL zero_lat: got %0d expected 1", de); end
    vectors++; if (bz != 0) begin miscompares++; $display("FAIL zero_busy: got %0d expected 0", bz); end
    vectors++; if (avg !== 16'd0) begin miscompares++; $display("FAIL zero_avg: got %0d expected 0", avg); end
    vectors++; if (rem !== 16'd0) begin miscompares++; $display("FAIL zero_rem: got %0d expected 0", rem); end
    vectors++; if (dz !== 1'b1) begin miscompares++; $display("FAIL zero_dz: got %0b expected 1", dz); end
  endtask

  task automatic test_saturate();
    repeat (256) step(0, 1, 255, 0);
    vectors++; if (sample_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_cnt: got %0d expected 255", sample_cnt); end
    vectors++; if (sat !== 1'b1) begin miscompares++; $display("FAIL sat_set: got %0b expected 1", sat); end
    step(0, 0, 0, 1);
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL sat_clr: got %0b expected 0", sat); end
    repeat (20) step(0, 0, 0, 0);
    vectors++; if (avg !== 16'd255) begin miscompares++; $display("FAIL sat_avg: got %0d expected 255", avg); end
    vectors++; if (rem !== 16'd0) begin miscompares++; $display("FAIL sat_rem: got %0d expected 0", rem); end
    vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL sat_dz: got %0b expected 0", dz); end
  endtask

  task automatic test_coincident();
    int dn;
    dn = 0;
    step(0, 1, 10, 0);
    step(0, 1, 10, 0);
    step(0, 1, 7, 1);
    vectors++; if (sample_cnt !== 8'd0) begin miscompares++; $display("FAIL coin_newwin: got %0d expected 0", sample_cnt); end
    step(0, 1, 5, 0);
    step(0, 1, 5, 0);
    repeat (16) begin
      step(0, 0, 0, 0);
      if (done === 1'b1) begin
        dn++;
        vectors++; if (sample_cnt !== 8'd2) begin miscompares++; $display("FAIL coin_cnt: got %0d expected 2", sample_cnt); end
      end
    end
    vectors++; if (dn != 1) begin miscompares++; $display("FAIL coin_ndone: got %0d expected 1", dn); end
    vectors++; if (avg !== 16'd9) begin miscompares++; $display("FAIL coin_avg: got %0d expected 9", avg); end
    vectors++; if (rem !== 16'd0) begin miscompares++; $display("FAIL coin_rem: got %0d expected 0", rem); end
  endtask

  task automatic test_ignore_req();
    int dn;
    dn = 0;
    step(0, 0, 0, 1);
    for (int k = 1; k <= 24; k++) begin
      step(0, 0, 0, (k == 5 || k == 12));
      if (done === 1'b1) dn++;
    end
    vectors++; if (dn != 1) begin miscompares++; $display("FAIL ign_ndone: got %0d expected 1", dn); end
    vectors++; if (avg !== 16'd5) begin miscompares++; $display("FAIL ign_avg: got %0d expected 5", avg); end
    vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL ign_dz: got %0b expected 0", dz); end
  endtask

  task automatic test_reset_div();
    int dn, ea;
`ifdef AVG_ROUND_EN
    ea = 8;
`else
    ea = 7;
`endif
    dn = 0;
    step(0, 1, 30, 0);
    step(0, 1, 40, 0);
    step(0, 0, 0, 1);
    repeat (7) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    vectors++; if ({busy, done, dz, sat} !== 4'b0) begin miscompares++; $display("FAIL rdiv_flags: got %b expected 0000", {busy, done, dz, sat}); end
    vectors++; if ({avg, rem} !== 32'd0) begin miscompares++; $display("FAIL rdiv_data: got %0d/%0d expected 0/0", avg, rem); end
    vectors++; if (sample_cnt !== 8'd0) begin miscompares++; $display("FAIL rdiv_cnt: got %0d expected 0", sample_cnt); end
    repeat (12) begin
      step(0, 0, 0, 0);
      if (done === 1'b1) dn++;
    end
    vectors++; if (dn != 0) begin miscompares++; $display("FAIL rdiv_nodone: got %0d expected 0", dn); end
    step(0, 1, 6, 0);
    step(0, 1, 9, 0);
    step(0, 0, 0, 1);
    repeat (20) begin
      step(0, 0, 0, 0);
      if (done === 1'b1) dn++;
    end
    vectors++; if (dn != 1) begin miscompares++; $display("FAIL rdiv_ndone: got %0d expected 1", dn); end
    vectors++; if (avg !== 16'(ea)) begin miscompares++; $display("FAIL rdiv_avg: got %0d expected %0d", avg, ea); end
    vectors++; if (rem !== 16'd1) begin miscompares++; $display("FAIL rdiv_rem: got %0d expected 1", rem); end
  endtask

  task automatic test_random();
    bit rs, v, r;
    int s;
    for (int n = 0; n < 3000; n++) begin
      rs = ($urandom_range(0, 599) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = $urandom_range(0, 255);
      r = ($urandom_range(0, 29) == 0);
      step(rs, v, s, r);
      vectors++; if (done !== m_done) begin miscompares++; $display("FAIL rnd_done: got %0b expected %0b edge %0d", done, m_done, e); end
      vectors++; if (busy !== m_busy) begin miscompares++; $display("FAIL rnd_busy: got %0b expected %0b edge %0d", busy, m_busy, e); end
      vectors++; if (sample_cnt !== 8'(m_cnt)) begin miscompares++; $display("FAIL rnd_cnt: got %0d expected %0d edge %0d", sample_cnt, m_cnt, e); end
      vectors++; if (sat !== m_sat) begin miscompares++; $display("FAIL rnd_sat: got %0b expected %0b edge %0d", sat, m_sat, e); end
      vectors++; if (avg !== 16'(x_avg)) begin miscompares++; $display("FAIL rnd_avg: got %0d expected %0d edge %0d", avg, x_avg, e); end
      vectors++; if (rem !== 16'(x_rem)) begin miscompares++; $display("FAIL rnd_rem: got %0d expected %0d edge %0d", rem, x_rem, e); end
      vectors++; if (dz !== x_dz) begin miscompares++; $display("FAIL rnd_dz: got %0b expected %0b edge %0d", dz, x_dz, e); end
    end
  endtask

  initial begin
    reset = 1'b1;
    sample_valid = 1'b0;
    sample = 8'd0;
    avg_req = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_saturate();
    test_coincident();
    test_ignore_req();
    test_reset_div();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
